// File: rtl/wb_pkg.sv
// Shared types and width helpers for the writeback arbiter.
//   wb_req_t  : one writeback request (destination index + data) at default widths
//   cnt_width : width of an occupancy counter able to hold 0..depth
//   ptr_width : width of a read/write pointer into a depth-entry buffer
package wb_pkg;

   localparam int DefDataWidth  = 64;
   localparam int DefNumRegs    = 32;
   localparam int DefIndexWidth = $clog2(DefNumRegs);
   localparam int DefFifoDepth  = 4;

   typedef struct packed {
      logic [DefIndexWidth-1:0] addr;
      logic [DefDataWidth-1:0]  data;
   } wb_req_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding load results until an ALU-idle cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (pointers and count)
//   push, wdata   : enqueue wdata (caller only pushes when not full)
//   pop, rdata    : rdata is the current head; pop advances past it
//                   (caller only pops when not empty)
//   full, empty   : occupancy flags derived from the registered count
//   count         : current occupancy, 0..Depth
module wb_fifo
   import wb_pkg::*;
#(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [Width-1:0]            wdata,
   output logic [Width-1:0]            rdata,
   output logic                        full,
   output logic                        empty,
   output logic [cnt_width(Depth)-1:0] count
);

   localparam int PtrW = ptr_width(Depth);
   localparam int CntW = cnt_width(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wptr;
   logic [PtrW-1:0]  rptr;

   // Storage carries no reset; stale entries are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wdata;
      end
   end

   // Depth is a power of two, so natural pointer overflow gives the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rptr];
   assign full  = (count == CntW'(Depth));
   assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file write port. ALU results
// always win; buffered load results drain on ALU-idle cycles. One registered
// write per cycle, plus a pending-write scoreboard for the issue stage.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   alu_valid/addr/data          : ALU result, never stalled
//   ld_valid/ready/addr/data     : load result with valid/ready handshake
//   mark_en, mark_addr           : issue stage reserves a destination register
//   rd_addr1/2, rd_busy1/2       : combinational busy lookup for source registers
//   writeEn, writeAddr, writeData: registered register-file write port
//   fifo_count                   : load buffer occupancy
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DataWidth  = DefDataWidth,
   parameter int NumRegs    = DefNumRegs,
   parameter int IndexWidth = $clog2(NumRegs),
   parameter int FifoDepth  = DefFifoDepth
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            alu_valid,
   input  logic [IndexWidth-1:0]           alu_addr,
   input  logic [DataWidth-1:0]            alu_data,
   input  logic                            ld_valid,
   output logic                            ld_ready,
   input  logic [IndexWidth-1:0]           ld_addr,
   input  logic [DataWidth-1:0]            ld_data,
   input  logic                            mark_en,
   input  logic [IndexWidth-1:0]           mark_addr,
   input  logic [IndexWidth-1:0]           rd_addr1,
   input  logic [IndexWidth-1:0]           rd_addr2,
   output logic                            rd_busy1,
   output logic                            rd_busy2,
   output logic                            writeEn,
   output logic [IndexWidth-1:0]           writeAddr,
   output logic [DataWidth-1:0]            writeData,
   output logic [cnt_width(FifoDepth)-1:0] fifo_count
);

   typedef struct packed {
      logic [IndexWidth-1:0] addr;
      logic [DataWidth-1:0]  data;
   } req_t;

   localparam int ReqW = $bits(req_t);

   req_t               ld_req;
   req_t               head;
   req_t               sel_req_p0;
   logic               sel_vld_p0;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [NumRegs-1:0] busy;
   logic [NumRegs-1:0] busy_nxt;

   assign ld_req = '{addr: ld_addr, data: ld_data};

   // Ready comes from the registered count only, so it never depends on
   // whether the ALU happens to block a drain this cycle.
   assign ld_ready = !full;
   assign push     = ld_valid && !full;
   assign pop      = !alu_valid && !empty;

   wb_fifo #(
      .Width (ReqW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (ld_req),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // ---- stage p0: select ALU result, else FIFO head ----
   always_comb begin
      sel_vld_p0 = 1'b0;
      sel_req_p0 = head;
      if (alu_valid) begin
         sel_vld_p0 = 1'b1;
         sel_req_p0 = '{addr: alu_addr, data: alu_data};
      end else if (!empty) begin
         sel_vld_p0 = 1'b1;
      end
   end

   // ---- stage p1: registered register-file write ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         writeEn   <= 1'b0;
         writeAddr <= '0;
         writeData <= '0;
      end else begin
         writeEn <= sel_vld_p0;
         if (sel_vld_p0) begin
            writeAddr <= sel_req_p0.addr;
            writeData <= sel_req_p0.data;
         end
      end
   end

   // Clear for the write committing at this edge, then apply the new mark,
   // so a same-edge mark of the committing index keeps the bit set.
   always_comb begin
      busy_nxt = busy;
      if (writeEn) busy_nxt[writeAddr] = 1'b0;
      if (mark_en) busy_nxt[mark_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign rd_busy1 = busy[rd_addr1];
   assign rd_busy2 = busy[rd_addr2];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   localparam int DW    = 64;
   localparam int NR    = 32;
   localparam int IW    = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0;
   logic [IW-1:0] alu_addr = '0;
   logic [DW-1:0] alu_data = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [IW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          mark_en = 1'b0;
   logic [IW-1:0] mark_addr = '0;
   logic [IW-1:0] rd_addr1 = '0;
   logic [IW-1:0] rd_addr2 = '0;
   logic          rd_busy1, rd_busy2;
   logic          writeEn;
   logic [IW-1:0] writeAddr;
   logic [DW-1:0] writeData;
   logic [CW-1:0] fifo_count;

   wb_arbiter #(
      .DataWidth (DW),
      .NumRegs   (NR),
      .IndexWidth(IW),
      .FifoDepth (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_busy1  (rd_busy1),
      .rd_busy2  (rd_busy2),
      .writeEn   (writeEn),
      .writeAddr (writeAddr),
      .writeData (writeData),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of buffered loads, a queue of expected writes
   // in commit order, and one reservation bit per register.
   typedef struct {
      logic [IW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t     mfifo[$];
   ent_t     expq[$];
   bit [NR-1:0] mbusy = '0;
   bit       m_we = 1'b0;
   bit [IW-1:0] m_addr = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mfifo.delete();
         expq.delete();
         mbusy = '0;
         m_we  = 1'b0;
      end else begin
         ent_t e;
         bit   accept;
         bit   sel;
         if (m_we) mbusy[m_addr] = 1'b0;
         if (mark_en) mbusy[mark_addr] = 1'b1;
         accept = ld_valid && (mfifo.size() < DEPTH);
         sel = 1'b0;
         if (alu_valid) begin
            e.a = alu_addr;
            e.d = alu_data;
            sel = 1'b1;
         end else if (mfifo.size() > 0) begin
            e = mfifo.pop_front();
            sel = 1'b1;
         end
         if (accept) begin
            ent_t n;
            n.a = ld_addr;
            n.d = ld_data;
            mfifo.push_back(n);
         end
         m_we = sel;
         if (sel) begin
            m_addr = e.a;
            expq.push_back(e);
         end
      end
   end

   // Monitor: samples mid-cycle, pops an expected write whenever writeEn shows.
   always @(negedge clk) begin
      if (!rst) begin
         check("writeEn", 64'(writeEn), 64'(m_we));
         check("fifo_count", 64'(fifo_count), 64'(mfifo.size()));
         check("ld_ready", 64'(ld_ready), 64'(mfifo.size() < DEPTH));
         check("rd_busy1", 64'(rd_busy1), 64'(mbusy[rd_addr1]));
         check("rd_busy2", 64'(rd_busy2), 64'(mbusy[rd_addr2]));
         if (writeEn) begin
            if (expq.size() == 0) begin
               check("unexpected_write", 64'(1), 64'(0));
            end else begin
               ent_t e;
               e = expq.pop_front();
               check("writeAddr", 64'(writeAddr), 64'(e.a));
               check("writeData", writeData, e.d);
            end
         end
      end
   end

   task automatic drive(input bit av, input logic [IW-1:0] aa, input logic [DW-1:0] ad,
                        input bit lv, input logic [IW-1:0] la, input logic [DW-1:0] ldd,
                        input bit me, input logic [IW-1:0] ma);
      alu_valid = av; alu_addr = aa; alu_data = ad;
      ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
      mark_en   = me; mark_addr = ma;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_writeEn", 64'(writeEn), 64'(0));
      check("reset_count", 64'(fifo_count), 64'(0));
      check("reset_ld_ready", 64'(ld_ready), 64'(1));
      check("reset_busy", 64'(rd_busy1), 64'(0));
      rst = 1'b0;
      idle(2);

      // ALU path
      drive(1, 5'd7, 64'hDEAD, 0, 0, 0, 0, 0);
      check("alu_n1_we", 64'(writeEn), 64'(1));
      check("alu_n1_addr", 64'(writeAddr), 64'(7));
      check("alu_n1_data", writeData, 64'hDEAD);
      idle(3);

      // Priority: 4 ALU writes, loads 1..3 arriving meanwhile, then drain
      for (int i = 0; i < 4; i++)
         drive(1, IW'(20 + i), 64'(100 + i), i < 3, IW'(i + 1), 64'(200 + i), 0, 0);
      idle(6);

      // Full and wrap
      for (int i = 0; i < 6; i++)
         drive(1, IW'(10 + i), 64'(300 + i), 1, IW'(i), 64'(400 + i), 0, 0);
      check("full_count", 64'(fifo_count), 64'(DEPTH));
      check("full_ready", 64'(ld_ready), 64'(0));
      for (int i = 0; i < 2 * DEPTH; i++)
         drive(0, 0, 0, 1, IW'(i + 16), 64'(500 + i), 0, 0);
      idle(8);

      // Scoreboard: mark, clear at commit, mark on commit edge
      rd_addr1 = 5'd9;
      drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
      check("mark_busy", 64'(rd_busy1), 64'(1));
      drive(1, 5'd9, 64'h99, 0, 0, 0, 0, 0);
      check("busy_before_commit", 64'(rd_busy1), 64'(1));
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("busy_cleared", 64'(rd_busy1), 64'(0));
      drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
      drive(1, 5'd9, 64'h999, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
      check("mark_wins", 64'(rd_busy1), 64'(1));
      idle(3);

      // Simultaneous push and pop at count 2
      drive(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 0);
      drive(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0, 0);
      check("pp_pre_count", 64'(fifo_count), 64'(2));
      drive(0, 0, 0, 1, 5'd6, 64'h66, 0, 0);
      check("pp_count", 64'(fifo_count), 64'(2));
      idle(6);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rd_addr1 = IW'($urandom);
         rd_addr2 = IW'($urandom);
         drive($urandom_range(0, 99) < 50, IW'($urandom), {$urandom, $urandom},
               $urandom_range(0, 99) < 45, IW'($urandom), {$urandom, $urandom},
               $urandom_range(0, 99) < 30, IW'($urandom));
      end
      idle(8);

      // Mid-stream reset with FIFO at 3 and register 5 reserved
      rd_addr1 = 5'd5;
      drive(1, 5'd8, 64'h1, 1, 5'd1, 64'hA1, 1, 5'd5);
      drive(1, 5'd8, 64'h2, 1, 5'd2, 64'hA2, 0, 0);
      drive(1, 5'd8, 64'h3, 1, 5'd3, 64'hA3, 0, 0);
      check("pre_rst_count", 64'(fifo_count), 64'(3));
      check("pre_rst_busy", 64'(rd_busy1), 64'(1));
      alu_valid = 1'b1; ld_valid = 1'b0; mark_en = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_writeEn", 64'(writeEn), 64'(0));
      check("rst_count", 64'(fifo_count), 64'(0));
      check("rst_ld_ready", 64'(ld_ready), 64'(1));
      check("rst_busy5", 64'(rd_busy1), 64'(0));
      alu_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      drive(0, 0, 0, 1, 5'd12, 64'hBEEF, 0, 0);
      idle(6);

      check("expq_drained", 64'(expq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
